// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives a 1-cycle synchronous ROM, handles stalls and jump/branch redirects.
// Optional macro FETCH_BEX_EN lets bex_taken redirect to jp_target; otherwise bex_taken is ignored.
module fetch_unit (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  output logic [11:0]        imem_addr,
  input  logic [31:0]        imem_q,
  output logic [31:0]        insn,
  output logic [11:0]        insn_pc,
  output logic               insn_valid,
  output logic [11:0]        pc_plus1,
  input  logic               jp,
  input  logic [26:0]        jp_target,
  input  logic               jr,
  input  logic [31:0]        jr_target,
  input  logic               br_taken,
  input  logic signed [16:0] br_offset,
  input  logic               bex_taken
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;

  logic [1:0]  state;
  logic [11:0] pc_q;
  logic [11:0] req_pc;
  logic        run;
  logic        bex_hit;
  logic        redirect;
  logic [11:0] target;
  logic        unused_bits;

  // Address arithmetic is modulo 4096; carries out of bit 11 are dropped.
  function automatic logic [11:0] addr_inc(input logic [11:0] a);
    return a + 12'd1;
  endfunction

  function automatic logic [11:0] branch_target(input logic [11:0]        pc,
                                                input logic signed [16:0] offset);
    return addr_inc(pc) + offset[11:0];
  endfunction

`ifdef FETCH_BEX_EN
  assign bex_hit     = bex_taken;
  assign unused_bits = ^{jp_target[26:12], jr_target[31:12], br_offset[16:12]};
`else
  assign bex_hit     = 1'b0;
  assign unused_bits = ^{jp_target[26:12], jr_target[31:12], br_offset[16:12], bex_taken};
`endif

  assign run        = (state == RUN);
  assign insn_valid = run;
  assign insn_pc    = req_pc;
  assign insn       = imem_q;
  assign pc_plus1   = addr_inc(req_pc);
  // A stalled ROM re-reads the in-flight address so insn stays stable.
  assign imem_addr  = (run && stall) ? req_pc : pc_q;
  assign redirect   = insn_valid && !stall && (jp || jr || bex_hit || br_taken);

  always_comb begin
    target = branch_target(req_pc, br_offset);
    if (jp)
      target = jp_target[11:0];
    else if (jr)
      target = jr_target[11:0];
    else if (bex_hit)
      target = jp_target[11:0];
  end

  // Fetch state: pc_q is the next fetch address, req_pc the word the ROM returns this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= 12'd0;
      req_pc <= 12'd0;
      state  <= BOOT;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            if (redirect) begin
              pc_q  <= target;
              state <= SQUASH;
            end else begin
              req_pc <= pc_q;
              pc_q   <= addr_inc(pc_q);
            end
          end
        end
        default: begin
          req_pc <= pc_q;
          pc_q   <= addr_inc(pc_q);
          state  <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural ROM feeds the DUT, expected (valid, pc) pairs are queued and popped per cycle.
module tb_fetch_unit;

  typedef struct packed {
    logic        v;
    logic [11:0] pc;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               stall = 1'b0;
  logic [11:0]        imem_addr;
  logic [31:0]        imem_q = 32'd0;
  logic [31:0]        insn;
  logic [11:0]        insn_pc;
  logic               insn_valid;
  logic [11:0]        pc_plus1;
  logic               jp = 1'b0;
  logic [26:0]        jp_target = 27'd0;
  logic               jr = 1'b0;
  logic [31:0]        jr_target = 32'd0;
  logic               br_taken = 1'b0;
  logic signed [16:0] br_offset = 17'sd0;
  logic               bex_taken = 1'b0;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .imem_addr(imem_addr), .imem_q(imem_q),
    .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid), .pc_plus1(pc_plus1),
    .jp(jp), .jp_target(jp_target), .jr(jr), .jr_target(jr_target),
    .br_taken(br_taken), .br_offset(br_offset), .bex_taken(bex_taken)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return {8'hA5, ~a, a};
  endfunction

  always @(posedge clock) imem_q <= rom_word(imem_addr);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; jp = 1'b0; jp_target = 27'd0; jr = 1'b0; jr_target = 32'd0;
    br_taken = 1'b0; br_offset = 17'sd0; bex_taken = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Leaves the DUT in RUN with insn_pc == n valid.
  task automatic run_to(input logic [11:0] n);
    do_reset();
    tick();
    if (n != 12'd0) begin
      jp = 1'b1;
      jp_target = {15'd0, n};
      tick();
      jp = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    exp_t e;
    clear_inputs();
    reset = 1'b1; stall = 1'b1; jp = 1'b1; jp_target = 27'h123; br_taken = 1'b1;
    tick();
    tick();
    total++; if (imem_addr !== 12'd0) begin bad++; $display("FAIL reset_imem_addr got=%0h want=0", imem_addr); end
    total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", insn_valid); end
    total++; if (insn_pc !== 12'd0) begin bad++; $display("FAIL reset_insn_pc got=%0h want=0", insn_pc); end
    total++; if (pc_plus1 !== 12'd1) begin bad++; $display("FAIL reset_pc_plus1 got=%0h want=1", pc_plus1); end
    do_reset();
    tick(); tick(); tick();
    stall = 1'b1; jp = 1'b1; jp_target = 27'h77; reset = 1'b1;
    tick();
    total++;
    if (insn_valid !== 1'b0 || insn_pc !== 12'd0 || imem_addr !== 12'd0 || pc_plus1 !== 12'd1) begin
      bad++;
      $display("FAIL midreset valid/pc/addr/plus1 got=%b/%0h/%0h/%0h want=0/0/0/1", insn_valid, insn_pc, imem_addr, pc_plus1);
    end
    reset = 1'b0; jp = 1'b0;
    sb.push_back(exp_t'{1'b1, 12'd0});
    sb.push_back(exp_t'{1'b1, 12'd0});
    sb.push_back(exp_t'{1'b1, 12'd1});
    for (int i = 0; i < 3; i++) begin
      stall = (i < 2);
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || (e.v && (insn_pc !== e.pc || insn !== rom_word(e.pc)))) begin
        bad++;
        $display("FAIL boot[%0d] valid/pc/insn got=%b/%0h/%h want=%b/%0h/%h", i, insn_valid, insn_pc, insn, e.v, e.pc, rom_word(e.pc));
      end
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) sb.push_back(exp_t'{1'b1, 12'(i)});
    for (int i = 0; i < 5; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || insn_pc !== e.pc || insn !== rom_word(e.pc) || pc_plus1 !== e.pc + 12'd1) begin
        bad++;
        $display("FAIL seq[%0d] valid/pc/insn/plus1 got=%b/%0h/%h/%0h want=%b/%0h/%h/%0h", i, insn_valid, insn_pc, insn, pc_plus1, e.v, e.pc, rom_word(e.pc), e.pc + 12'd1);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    run_to(12'd5);
    sb.push_back(exp_t'{1'b0, 12'd0});
    sb.push_back(exp_t'{1'b1, 12'd3});
    sb.push_back(exp_t'{1'b1, 12'd4});
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      if (i == 0) begin br_taken = 1'b1; br_offset = 17'sh1FFFD; end
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || (e.v && (insn_pc !== e.pc || insn !== rom_word(e.pc)))) begin
        bad++;
        $display("FAIL branch[%0d] valid/pc/insn got=%b/%0h/%h want=%b/%0h/%h", i, insn_valid, insn_pc, insn, e.v, e.pc, rom_word(e.pc));
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    run_to(12'd10);
    stall = 1'b1;
    #1;
    total++; if (imem_addr !== 12'd10) begin bad++; $display("FAIL stall_addr got=%0h want=a", imem_addr); end
    for (int i = 0; i < 3; i++) sb.push_back(exp_t'{1'b1, 12'd10});
    sb.push_back(exp_t'{1'b1, 12'd11});
    sb.push_back(exp_t'{1'b1, 12'd12});
    for (int i = 0; i < 5; i++) begin
      stall = (i < 3);
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || insn_pc !== e.pc || insn !== rom_word(e.pc) || (stall && imem_addr !== 12'd10)) begin
        bad++;
        $display("FAIL stall[%0d] valid/pc/insn/addr got=%b/%0h/%h/%0h want=%b/%0h/%h/a", i, insn_valid, insn_pc, insn, imem_addr, e.v, e.pc, rom_word(e.pc));
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    run_to(12'd4);
    total++; if (pc_plus1 !== 12'd5) begin bad++; $display("FAIL prio_pc_plus1 got=%0h want=5", pc_plus1); end
    sb.push_back(exp_t'{1'b0, 12'd0});
    sb.push_back(exp_t'{1'b1, 12'h100});
    sb.push_back(exp_t'{1'b1, 12'h101});
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      if (i == 0) begin
        jp = 1'b1; jp_target = 27'h0000100; jr = 1'b1; jr_target = 32'h20;
        br_taken = 1'b1; br_offset = 17'sd5; bex_taken = 1'b1;
      end
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || (e.v && (insn_pc !== e.pc || insn !== rom_word(e.pc)))) begin
        bad++;
        $display("FAIL jp_prio[%0d] valid/pc got=%b/%0h want=%b/%0h", i, insn_valid, insn_pc, e.v, e.pc);
      end
    end
    run_to(12'd20);
    sb.push_back(exp_t'{1'b0, 12'd0});
    sb.push_back(exp_t'{1'b1, 12'h030});
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      if (i == 0) begin
        jr = 1'b1; jr_target = 32'hABCD_E030; br_taken = 1'b1; br_offset = 17'sd7;
        bex_taken = 1'b1; jp_target = 27'h55;
      end
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || (e.v && (insn_pc !== e.pc || insn !== rom_word(e.pc)))) begin
        bad++;
        $display("FAIL jr_prio[%0d] valid/pc got=%b/%0h want=%b/%0h", i, insn_valid, insn_pc, e.v, e.pc);
      end
    end
    run_to(12'd30);
    sb.push_back(exp_t'{1'b0, 12'd0});
`ifdef FETCH_BEX_EN
    sb.push_back(exp_t'{1'b1, 12'h077});
`else
    sb.push_back(exp_t'{1'b1, 12'd33});
`endif
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      if (i == 0) begin bex_taken = 1'b1; jp_target = 27'h77; br_taken = 1'b1; br_offset = 17'sd2; end
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || (e.v && (insn_pc !== e.pc || insn !== rom_word(e.pc)))) begin
        bad++;
        $display("FAIL bex_br_prio[%0d] valid/pc got=%b/%0h want=%b/%0h", i, insn_valid, insn_pc, e.v, e.pc);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    run_to(12'd4095);
    total++; if (pc_plus1 !== 12'd0) begin bad++; $display("FAIL wrap_pc_plus1 got=%0h want=0", pc_plus1); end
    sb.push_back(exp_t'{1'b1, 12'd0});
    sb.push_back(exp_t'{1'b1, 12'd1});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || insn_pc !== e.pc || insn !== rom_word(e.pc)) begin
        bad++;
        $display("FAIL wrap[%0d] valid/pc got=%b/%0h want=%b/%0h", i, insn_valid, insn_pc, e.v, e.pc);
      end
    end
    run_to(12'd4095);
    sb.push_back(exp_t'{1'b0, 12'd0});
    sb.push_back(exp_t'{1'b1, 12'd1});
    sb.push_back(exp_t'{1'b1, 12'd2});
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      if (i == 0) begin br_taken = 1'b1; br_offset = 17'sd1; end
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || (e.v && (insn_pc !== e.pc || insn !== rom_word(e.pc)))) begin
        bad++;
        $display("FAIL wrap_br[%0d] valid/pc got=%b/%0h want=%b/%0h", i, insn_valid, insn_pc, e.v, e.pc);
      end
    end
  endtask

  task automatic test_bex();
    exp_t e;
    run_to(12'd7);
`ifdef FETCH_BEX_EN
    sb.push_back(exp_t'{1'b0, 12'd0});
    sb.push_back(exp_t'{1'b1, 12'h040});
    sb.push_back(exp_t'{1'b1, 12'h041});
`else
    sb.push_back(exp_t'{1'b1, 12'd8});
    sb.push_back(exp_t'{1'b1, 12'd9});
    sb.push_back(exp_t'{1'b1, 12'd10});
`endif
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      if (i == 0) begin bex_taken = 1'b1; jp_target = 27'h40; end
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || (e.v && (insn_pc !== e.pc || insn !== rom_word(e.pc)))) begin
        bad++;
        $display("FAIL bex[%0d] valid/pc got=%b/%0h want=%b/%0h", i, insn_valid, insn_pc, e.v, e.pc);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    tick();
    sb.push_back(exp_t'{1'b0, 12'd0});
    sb.push_back(exp_t'{1'b1, 12'h200});
    sb.push_back(exp_t'{1'b0, 12'd0});
    sb.push_back(exp_t'{1'b1, 12'h206});
    sb.push_back(exp_t'{1'b1, 12'h207});
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      case (i)
        0: begin jp = 1'b1; jp_target = 27'h200; end
        1: begin jp = 1'b1; jp_target = 27'h333; stall = 1'b1; end
        2: begin br_taken = 1'b1; br_offset = 17'sd5; end
        default: ;
      endcase
      tick();
      e = sb.pop_front();
      total++;
      if (insn_valid !== e.v || (e.v && (insn_pc !== e.pc || insn !== rom_word(e.pc)))) begin
        bad++;
        $display("FAIL b2b[%0d] valid/pc got=%b/%0h want=%b/%0h", i, insn_valid, insn_pc, e.v, e.pc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_priority();
    test_wrap();
    test_bex();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
